// File: rtl/intctrl_if.sv
// Wishbone classic 32-bit bus bundle shared by intctrl and its bus masters.
// Handshake: a request is accepted when cyc & stb are high and no ack is pending; ack follows for exactly one cycle.
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;

  modport slave  (input cyc, stb, we, adr, sel, dat_i, output dat_o, ack);
  modport master (output cyc, stb, we, adr, sel, dat_i, input dat_o, ack);
endinterface

// File: rtl/intctrl.sv
// Interrupt controller: edge-latched pending bits, software mask, fixed priority (bit 0 highest).
// Optional macro INTCTRL_LEVEL_EN adds a LEVEL register making selected sources level-tracking.
module intctrl #(
  parameter int              NIRQ       = 8,
  parameter logic [NIRQ-1:0] RESET_MASK = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  if_wb.slave             bus,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            enabled,
  output logic [3:0]      cpu_exception
);
`ifdef INTCTRL_LEVEL_EN
  localparam int AW = 3;
`else
  localparam int AW = 2;
`endif
  localparam logic [AW-1:0] REG_PENDING = AW'(0);
  localparam logic [AW-1:0] REG_MASK    = AW'(1);
  localparam logic [AW-1:0] REG_ACTIVE  = AW'(2);
  localparam logic [AW-1:0] REG_VECTOR  = AW'(3);

  logic [NIRQ-1:0] pending_q, pending_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [NIRQ-1:0] irq_prev_q, irq_prev_d;
  logic [3:0]      cpu_exception_q, cpu_exception_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_o_q, dat_o_d;

  logic            accept;
  logic            wr_en;
  logic [AW-1:0]   reg_sel;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] w1c;
  logic [NIRQ-1:0] edge_next;
  logic [NIRQ-1:0] active;
  logic [3:0]      vec;
  logic [31:0]     rdata;
`ifdef INTCTRL_LEVEL_EN
  localparam logic [AW-1:0] REG_LEVEL = AW'(4);
  logic [NIRQ-1:0] level_q, level_d;
`endif

  // Only sel[0] gates writes, so the upper lanes and address bits are don't-care.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.adr[31:AW+2], bus.adr[1:0], bus.sel[3:1], bus.dat_i[31:NIRQ]};

  always_comb begin
    accept     = bus.cyc & bus.stb & ~ack_q;
    wr_en      = accept & bus.we & bus.sel[0];
    reg_sel    = bus.adr[AW+1:2];
    rise       = irq_in & ~irq_prev_q;
    irq_prev_d = irq_in;
    w1c        = (wr_en && reg_sel == REG_PENDING) ? bus.dat_i[NIRQ-1:0] : '0;
    mask_d     = (wr_en && reg_sel == REG_MASK) ? bus.dat_i[NIRQ-1:0] : mask_q;
    // A rise in the same cycle as its clear wins, so no event is lost.
    edge_next  = (pending_q & ~w1c) | rise;
`ifdef INTCTRL_LEVEL_EN
    level_d    = (wr_en && reg_sel == REG_LEVEL) ? bus.dat_i[NIRQ-1:0] : level_q;
    pending_d  = (level_q & irq_in) | (~level_q & edge_next);
`else
    pending_d  = edge_next;
`endif
  end

  always_comb begin
    active = pending_q & mask_q;
    vec    = 4'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (active[i]) vec = 4'(i + 1);
    end
    cpu_exception_d = enabled ? vec : 4'd0;
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      REG_PENDING: rdata[NIRQ-1:0] = pending_q;
      REG_MASK:    rdata[NIRQ-1:0] = mask_q;
      REG_ACTIVE:  rdata[NIRQ-1:0] = active;
      REG_VECTOR:  rdata[3:0]      = vec;
`ifdef INTCTRL_LEVEL_EN
      REG_LEVEL:   rdata[NIRQ-1:0] = level_q;
`endif
      default:     rdata = 32'd0;
    endcase
    ack_d   = accept;
    dat_o_d = (accept && !bus.we) ? rdata : 32'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q       <= '0;
      mask_q          <= RESET_MASK;
      irq_prev_q      <= '0;
      cpu_exception_q <= 4'd0;
      ack_q           <= 1'b0;
      dat_o_q         <= 32'd0;
`ifdef INTCTRL_LEVEL_EN
      level_q         <= '0;
`endif
    end else begin
      pending_q       <= pending_d;
      mask_q          <= mask_d;
      irq_prev_q      <= irq_prev_d;
      cpu_exception_q <= cpu_exception_d;
      ack_q           <= ack_d;
      dat_o_q         <= dat_o_d;
`ifdef INTCTRL_LEVEL_EN
      level_q         <= level_d;
`endif
    end
  end

  assign bus.ack       = ack_q;
  assign bus.dat_o     = dat_o_q;
  assign cpu_exception = cpu_exception_q;
endmodule

// File: tb/tb_intctrl.sv
// Bench for intctrl: register table, directed corner sequences, and random traffic against a cycle model.
module tb_intctrl;
  localparam int NIRQ = 8;
`ifdef INTCTRL_LEVEL_EN
  localparam int AW = 3;
`else
  localparam int AW = 2;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NIRQ-1:0] irq_in = '0;
  logic            enabled = 1'b0;
  logic [3:0]      cpu_exception;

  if_wb wb();

  intctrl #(.NIRQ(NIRQ), .RESET_MASK(8'h00)) dut (
    .clk_i(clk), .rst_i(rst), .bus(wb), .irq_in(irq_in),
    .enabled(enabled), .cpu_exception(cpu_exception)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [NIRQ-1:0] m_pend = '0, m_mask = '0, m_prev = '0, m_level = '0;
  logic            m_ack = 1'b0;
  logic [31:0]     m_dat = 32'd0;
  logic [3:0]      exp_q[$];
  logic [3:0]      mon_exp;

  function automatic logic [3:0] ref_vec(input logic [NIRQ-1:0] act);
    for (int i = 0; i < NIRQ; i++) if (act[i]) return 4'(i + 1);
    return 4'd0;
  endfunction

  function automatic logic [31:0] ref_read(input int idx);
    case (idx)
      0: return {24'd0, m_pend};
      1: return {24'd0, m_mask};
      2: return {24'd0, m_pend & m_mask};
      3: return {28'd0, ref_vec(m_pend & m_mask)};
      4: return {24'd0, m_level};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    int idx;
    logic acc, wr;
    logic [NIRQ-1:0] np;
    idx = int'(wb.adr[AW+1:2]);
    acc = wb.cyc && wb.stb && !m_ack;
    wr  = acc && wb.we && wb.sel[0];
    exp_q.push_back(enabled ? ref_vec(m_pend & m_mask) : 4'd0);
    m_dat = (acc && !wb.we) ? ref_read(idx) : 32'd0;
    m_ack = acc;
    for (int i = 0; i < NIRQ; i++) begin
      if (m_level[i])                    np[i] = irq_in[i];
      else if (irq_in[i] && !m_prev[i])  np[i] = 1'b1;
      else if (wr && idx == 0 && wb.dat_i[i]) np[i] = 1'b0;
      else                               np[i] = m_pend[i];
    end
    m_pend = np;
    if (wr && idx == 1) m_mask = wb.dat_i[NIRQ-1:0];
    if (wr && idx == 4) m_level = wb.dat_i[NIRQ-1:0];
    m_prev = irq_in;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_pend = '0; m_mask = 8'h00; m_prev = '0; m_level = '0;
        m_ack = 1'b0; m_dat = 32'd0;
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
        check("model_cpu_exception", {28'd0, cpu_exception}, {28'd0, mon_exp});
        check("model_ack", {31'd0, wb.ack}, {31'd0, m_ack});
        check("model_dat_o", wb.dat_o, m_dat);
      end
    end
  end

  // Driver tasks
  task automatic wb_xfer(input logic we, input int idx, input logic [31:0] wdata,
                         input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we;
    wb.adr = 32'(idx) << 2; wb.sel = sel; wb.dat_i = wdata;
    lat = 0;
    rdata = 32'hdead_beef;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (wb.ack) begin
        lat = n;
        rdata = wb.dat_o;
      end
    end
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    if (lat == 0) check("wb_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_wr(input int idx, input logic [31:0] wdata);
    logic [31:0] d;
    int lat;
    wb_xfer(1'b1, idx, wdata, 4'hF, d, lat);
  endtask

  task automatic wb_rd(input int idx, input logic [31:0] exp, input string name);
    logic [31:0] d;
    int lat;
    wb_xfer(1'b0, idx, 32'd0, 4'hF, d, lat);
    check(name, d, exp);
  endtask

  task automatic pulse_irq(input int bitn);
    @(posedge clk); #1 irq_in[bitn] = 1'b1;
    @(posedge clk); #1 irq_in[bitn] = 1'b0;
  endtask

  typedef struct {
    logic        we;
    int          idx;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[14];

  logic [31:0] r_d;
  int          r_lat;
  int          acks;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1, 32'h05,  4'hF, 32'h0};
    tbl[1]  = '{1'b0, 1, 32'h0,   4'hF, 32'h5};
    tbl[2]  = '{1'b0, 0, 32'h0,   4'hF, 32'h0};
    tbl[3]  = '{1'b0, 2, 32'h0,   4'hF, 32'h0};
    tbl[4]  = '{1'b0, 3, 32'h0,   4'hF, 32'h0};
    tbl[5]  = '{1'b1, 1, 32'hFF,  4'h0, 32'h0};
    tbl[6]  = '{1'b0, 1, 32'h0,   4'hF, 32'h5};
    tbl[7]  = '{1'b1, 1, 32'h1FF, 4'h1, 32'h0};
    tbl[8]  = '{1'b0, 1, 32'h0,   4'hF, 32'hFF};
    tbl[9]  = '{1'b1, 2, 32'hFF,  4'hF, 32'h0};
    tbl[10] = '{1'b0, 2, 32'h0,   4'hF, 32'h0};
    tbl[11] = '{1'b1, 3, 32'hF,   4'hF, 32'h0};
    tbl[12] = '{1'b0, 3, 32'h0,   4'hF, 32'h0};
    tbl[13] = '{1'b0, 1, 32'h0,   4'hF, 32'hFF};

    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    wb.adr = 32'd0; wb.sel = 4'h0; wb.dat_i = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_exception", {28'd0, cpu_exception}, 32'd0);
    check("rst_ack", {31'd0, wb.ack}, 32'd0);
    check("rst_dat_o", wb.dat_o, 32'd0);
    rst = 1'b0;

    // Register table
    for (int i = 0; i < 14; i++) begin
      wb_xfer(tbl[i].we, tbl[i].idx, tbl[i].wdata, tbl[i].sel, r_d, r_lat);
      check($sformatf("tbl%0d_data", i), r_d, tbl[i].exp);
      check($sformatf("tbl%0d_latency", i), 32'(r_lat), 32'd1);
    end
    check("tbl_cpu_exception", {28'd0, cpu_exception}, 32'd0);
`ifdef INTCTRL_LEVEL_EN
    wb_rd(5, 32'd0, "adr5_zero");
    wb_rd(7, 32'd0, "adr7_zero");
`endif

    // Single pulse on source 3, held until cleared
    enabled = 1'b1;
    pulse_irq(3);
    check("a_n1", {28'd0, cpu_exception}, 32'd0);
    @(posedge clk); #1;
    check("a_n2", {28'd0, cpu_exception}, 32'd4);
    repeat (3) @(posedge clk);
    #1;
    check("a_hold", {28'd0, cpu_exception}, 32'd4);
    wb_wr(0, 32'h08);
    check("a_ack_cycle", {28'd0, cpu_exception}, 32'd4);
    @(posedge clk); #1;
    check("a_cleared", {28'd0, cpu_exception}, 32'd0);

    // Two sources together, priority and masking
    @(posedge clk); #1 irq_in = 8'h22;
    @(posedge clk); #1 irq_in = 8'h00;
    @(posedge clk); #1;
    check("b_cpu2", {28'd0, cpu_exception}, 32'd2);
    wb_rd(3, 32'd2, "b_vec2");
    wb_wr(0, 32'h02);
    wb_rd(3, 32'd6, "b_vec6");
    check("b_cpu6", {28'd0, cpu_exception}, 32'd6);
    wb_wr(1, 32'hDF);
    wb_rd(3, 32'd0, "b_vec_masked");
    wb_rd(0, 32'h20, "b_pend_kept");
    check("b_cpu_masked", {28'd0, cpu_exception}, 32'd0);
    wb_wr(1, 32'hFF);
    wb_wr(0, 32'h20);

    // Rise and W1C of the same bit in one cycle
    pulse_irq(2);
    wb_rd(0, 32'h04, "c_pend_before");
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.adr = 32'd0;
    wb.sel = 4'hF; wb.dat_i = 32'h04; irq_in[2] = 1'b1;
    @(posedge clk); #1;
    irq_in[2] = 1'b0;
    check("c_ack", {31'd0, wb.ack}, 32'd1);
    wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    wb_rd(0, 32'h04, "c_pend_kept");
    wb_rd(3, 32'd3, "c_vec3");
    check("c_cpu3", {28'd0, cpu_exception}, 32'd3);
    wb_wr(0, 32'h04);
    wb_rd(0, 32'h00, "c_pend_clear");

    // Global enable gating
    enabled = 1'b0;
    pulse_irq(4);
    repeat (3) @(posedge clk);
    #1;
    check("d_disabled", {28'd0, cpu_exception}, 32'd0);
    wb_rd(2, 32'h10, "d_active");
    wb_rd(3, 32'd5, "d_vecreg");
    @(posedge clk); #1 enabled = 1'b1;
    check("d_en_pre", {28'd0, cpu_exception}, 32'd0);
    @(posedge clk); #1;
    check("d_en_post", {28'd0, cpu_exception}, 32'd5);
    wb_wr(0, 32'h10);

    // Back-to-back requests: one ack every second cycle
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 32'h4;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (wb.ack) acks++;
    end
    wb.cyc = 1'b0; wb.stb = 1'b0;
    check("btb_acks", 32'(acks), 32'd3);

`ifdef INTCTRL_LEVEL_EN
    wb_wr(4, 32'h01);
    wb_rd(4, 32'h01, "l_level");
    @(posedge clk); #1 irq_in[0] = 1'b1;
    wb_rd(0, 32'h01, "l_pend_hi");
    wb_wr(0, 32'h01);
    wb_rd(0, 32'h01, "l_pend_w1c");
    check("l_cpu1", {28'd0, cpu_exception}, 32'd1);
    repeat (3) @(posedge clk);
    #1 irq_in[0] = 1'b0;
    @(posedge clk); #1;
    check("l_fall_n1", {28'd0, cpu_exception}, 32'd1);
    @(posedge clk); #1;
    check("l_fall_n2", {28'd0, cpu_exception}, 32'd0);
    wb_rd(0, 32'h00, "l_pend_lo");
    wb_wr(4, 32'h00);
`endif

    // Reset mid-transaction, source held high through reset
    irq_in = 8'h40;
    @(posedge clk); #1;
    wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 32'h4;
    @(posedge clk); #1;
    check("rst_pre_ack", {31'd0, wb.ack}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_ack_drop", {31'd0, wb.ack}, 32'd0);
    check("rst_dat_drop", wb.dat_o, 32'd0);
    wb.cyc = 1'b0; wb.stb = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    wb_rd(1, 32'h00, "rst_mask_default");
    wb_rd(0, 32'h40, "rst_held_high_event");
    wb_wr(0, 32'h40);
    wb_rd(0, 32'h00, "rst_no_reevent");
    irq_in = 8'h00;

    // Random traffic against the model
    fork
      begin
        for (int c = 0; c < 800; c++) begin
          @(posedge clk); #1;
          irq_in = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
          if ($urandom_range(0, 7) == 0) enabled = ~enabled;
        end
      end
      begin
        for (int t = 0; t < 200; t++) begin
          wb_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << AW) - 1)),
                  $urandom, 4'($urandom_range(0, 15)), r_d, r_lat);
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
    join

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
